// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, datapath width,
// reset PC default and the instruction length used to step the PC.
package cpu_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          ILEN         = 4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// One-entry valid/ready holding register with synchronous flush.
// Ports: clk, rst, flush, load/din (fill), ready (drain), valid/dout.
module fetch_buf
#(
    parameter int W = 64
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// Instruction fetch / PC unit: one outstanding imem request, redirect
// handling, one-entry decode buffer and sticky misaligned-target fault.
// Ports: clk, rst, doBranch/brTarget (redirect), imemReq/imemAddr/
// imemGnt/imemRvalid/imemRdata (memory), instValid/instData/instPC/
// instReady (decode), misaligned (fault).
module fetch_pc
    import cpu_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            doBranch,
    input  logic [XLEN-1:0] brTarget,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemGnt,
    input  logic            imemRvalid,
    input  logic [XLEN-1:0] imemRdata,
    output logic            instValid,
    output logic [XLEN-1:0] instData,
    output logic [XLEN-1:0] instPC,
    input  logic            instReady,
    output logic            misaligned
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            mis_q, mis_d;
    logic            flush, load, fire;
    logic [XLEN-1:0] tgt;
    logic [2*XLEN-1:0] buf_out;

    assign tgt = {brTarget[XLEN-1:1], 1'b0};

    // Only request when the fetched word will have a free slot.
    assign imemReq  = !rst && (state_q == ST_REQ)
                      && (!instValid || instReady);
    assign imemAddr = rst ? RESET_PC : pc_q;
    assign fire     = imemReq && imemGnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            mis_q    <= mis_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        mis_d    = mis_q;
        flush    = 1'b0;
        load     = 1'b0;
        if (state_q != ST_HALT && doBranch) begin
            flush = 1'b1;
            if (tgt[1]) begin
                mis_d   = 1'b1;
                state_d = ST_HALT;
            end else begin
                pc_d = tgt;
                // A granted request still owes us one rvalid; skip it.
                unique case (state_q)
                    ST_REQ:  state_d = fire ? ST_DROP : ST_REQ;
                    ST_WAIT: state_d = imemRvalid ? ST_REQ : ST_DROP;
                    ST_DROP: state_d = imemRvalid ? ST_REQ : ST_DROP;
                    default: state_d = state_q;
                endcase
            end
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (fire) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + XLEN'(ILEN);
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imemRvalid) begin
                        load    = 1'b1;
                        state_d = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imemRvalid) state_d = ST_REQ;
                end
                default: state_d = ST_HALT;
            endcase
        end
    end

    fetch_buf #(.W(2*XLEN)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .load  (load),
        .din   ({imemRdata, req_pc_q}),
        .ready (instReady),
        .valid (instValid),
        .dout  (buf_out)
    );

    assign instData   = buf_out[2*XLEN-1:XLEN];
    assign instPC     = buf_out[XLEN-1:0];
    assign misaligned = mis_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed testbench for fetch_pc with a switchable zero-wait memory
// responder; checks are immediate assertions sampled 2ns after each edge.
module tb_fetch_pc;

    logic        clk = 1'b0;
    logic        rst;
    logic        doBranch;
    logic [31:0] brTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        instValid;
    logic [31:0] instData;
    logic [31:0] instPC;
    logic        instReady;
    logic        misaligned;

    logic        autoMem, gntMan, rvMan;
    logic [31:0] rdMan;
    logic        pend = 1'b0;
    logic [31:0] alat = 32'h0;

    int nrun = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] sig(input logic [31:0] a);
        return a + 32'h1300_0013;
    endfunction

    // Zero-wait memory: grant with the request, data on the next cycle.
    always @(posedge clk) begin
        pend <= imemReq & imemGnt;
        alat <= imemAddr;
    end

    assign imemGnt    = autoMem ? imemReq : gntMan;
    assign imemRvalid = autoMem ? pend : rvMan;
    assign imemRdata  = autoMem ? sig(alat) : rdMan;

    fetch_pc dut (
        .clk        (clk),
        .rst        (rst),
        .doBranch   (doBranch),
        .brTarget   (brTarget),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemGnt    (imemGnt),
        .imemRvalid (imemRvalid),
        .imemRdata  (imemRdata),
        .instValid  (instValid),
        .instData   (instData),
        .instPC     (instPC),
        .instReady  (instReady),
        .misaligned (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nrun++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; doBranch = 1'b0; brTarget = '0; instReady = 1'b1;
        autoMem = 1'b1; gntMan = 1'b0; rvMan = 1'b0; rdMan = '0;

        // reset state
        step(); step(); settle();
        chk("rst_req", 32'(imemReq), 32'd0);
        chk("rst_addr", imemAddr, 32'h0);
        chk("rst_valid", 32'(instValid), 32'd0);
        chk("rst_data", instData, 32'h0);
        chk("rst_pc", instPC, 32'h0);
        chk("rst_mis", 32'(misaligned), 32'd0);

        // sequential fetch, zero-wait memory
        rst = 1'b0; settle();
        chk("seq_req0", 32'(imemReq), 32'd1);
        chk("seq_addr0", imemAddr, 32'h0);
        step(); settle();
        chk("seq_wait_req", 32'(imemReq), 32'd0);
        chk("seq_wait_valid", 32'(instValid), 32'd0);
        step(); settle();
        chk("seq_valid0", 32'(instValid), 32'd1);
        chk("seq_pc0", instPC, 32'h0);
        chk("seq_data0", instData, sig(32'h0));
        chk("seq_addr4", imemAddr, 32'h4);
        chk("seq_req4", 32'(imemReq), 32'd1);
        step(); settle();
        chk("seq_gap", 32'(instValid), 32'd0);
        step(); settle();
        chk("seq_pc4", instPC, 32'h4);
        chk("seq_data4", instData, sig(32'h4));
        chk("seq_addr8", imemAddr, 32'h8);
        step(); step(); settle();
        chk("seq_valid8", 32'(instValid), 32'd1);
        chk("seq_pc8", instPC, 32'h8);
        chk("seq_data8", instData, sig(32'h8));

        // back-pressure after a clean reset
        rst = 1'b1; settle();
        chk("rst_req_gate", 32'(imemReq), 32'd0);
        step(); settle();
        chk("rst2_valid", 32'(instValid), 32'd0);
        rst = 1'b0; instReady = 1'b0; settle();
        chk("bp_addr0", imemAddr, 32'h0);
        step(); step(); settle();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(instValid), 32'd1);
            chk("bp_pc", instPC, 32'h0);
            chk("bp_data", instData, sig(32'h0));
            chk("bp_req", 32'(imemReq), 32'd0);
            step(); settle();
        end
        instReady = 1'b1; settle();
        chk("bp_rel_req", 32'(imemReq), 32'd1);
        chk("bp_rel_addr", imemAddr, 32'h4);
        step(); settle();
        chk("bp_drained", 32'(instValid), 32'd0);
        step(); settle();
        chk("bp_pc4", instPC, 32'h4);
        chk("bp_addr8", imemAddr, 32'h8);

        // redirect while the fetch of 0x8 is in flight
        autoMem = 1'b0; gntMan = 1'b1; settle();
        step();
        gntMan = 1'b0; doBranch = 1'b1; brTarget = 32'h100; settle();
        chk("rw_req", 32'(imemReq), 32'd0);
        step();
        doBranch = 1'b0; rvMan = 1'b1; rdMan = 32'hDEAD_0001; settle();
        chk("rw_drop_valid", 32'(instValid), 32'd0);
        chk("rw_drop_req", 32'(imemReq), 32'd0);
        step();
        rvMan = 1'b0; gntMan = 1'b1; settle();
        chk("rw_stale_valid", 32'(instValid), 32'd0);
        chk("rw_req100", 32'(imemReq), 32'd1);
        chk("rw_addr100", imemAddr, 32'h100);
        step();
        gntMan = 1'b0; rvMan = 1'b1; rdMan = 32'h1234_0013; settle();
        chk("rw_wait_valid", 32'(instValid), 32'd0);
        step();
        rvMan = 1'b0; settle();
        chk("rw_valid", 32'(instValid), 32'd1);
        chk("rw_pc", instPC, 32'h100);
        chk("rw_data", instData, 32'h1234_0013);
        chk("rw_addr104", imemAddr, 32'h104);

        // redirect coincident with grant, JALR-style odd target
        gntMan = 1'b1; doBranch = 1'b1; brTarget = 32'h201; settle();
        step();
        gntMan = 1'b0; doBranch = 1'b0; rvMan = 1'b1; rdMan = 32'hBAD0_0BAD;
        settle();
        chk("cg_flush", 32'(instValid), 32'd0);
        chk("cg_req", 32'(imemReq), 32'd0);
        step();
        rvMan = 1'b0; autoMem = 1'b1; settle();
        chk("cg_no_stale", 32'(instValid), 32'd0);
        chk("cg_req200", 32'(imemReq), 32'd1);
        chk("cg_addr200", imemAddr, 32'h200);
        step(); settle();
        chk("cg_wait_valid", 32'(instValid), 32'd0);
        step(); settle();
        chk("cg_pc", instPC, 32'h200);
        chk("cg_data", instData, sig(32'h200));

        // misaligned target halts fetch
        doBranch = 1'b1; brTarget = 32'h102; settle();
        step();
        doBranch = 1'b0; settle();
        chk("mis_set", 32'(misaligned), 32'd1);
        chk("mis_valid", 32'(instValid), 32'd0);
        chk("mis_req", 32'(imemReq), 32'd0);
        step();
        doBranch = 1'b1; brTarget = 32'h300; settle();
        step();
        doBranch = 1'b0; settle();
        chk("halt_sticky", 32'(misaligned), 32'd1);
        chk("halt_req", 32'(imemReq), 32'd0);
        chk("halt_valid", 32'(instValid), 32'd0);
        step(); settle();
        chk("halt_req2", 32'(imemReq), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0; settle();
        chk("mis_clear", 32'(misaligned), 32'd0);
        chk("mis_rst_req", 32'(imemReq), 32'd1);
        chk("mis_rst_addr", imemAddr, 32'h0);

        // reset while a request is outstanding
        autoMem = 1'b0; gntMan = 1'b1; settle();
        step();
        gntMan = 1'b0; rst = 1'b1; rvMan = 1'b1; rdMan = 32'hBEEF_0000;
        settle();
        chk("mr_req", 32'(imemReq), 32'd0);
        chk("mr_addr", imemAddr, 32'h0);
        step();
        rst = 1'b0; rvMan = 1'b0; autoMem = 1'b1; settle();
        chk("mr_valid", 32'(instValid), 32'd0);
        chk("mr_req_after", 32'(imemReq), 32'd1);
        chk("mr_addr_after", imemAddr, 32'h0);
        step(); settle();
        chk("mr_wait_valid", 32'(instValid), 32'd0);
        step(); settle();
        chk("mr_valid0", 32'(instValid), 32'd1);
        chk("mr_pc0", instPC, 32'h0);
        chk("mr_data0", instData, sig(32'h0));

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Instruction-fetch / program-counter unit.
- Consumes the branch unit's redirect decision (doBranch plus target) and keeps one fetch request outstanding to instruction memory.
- Presents fetched instructions to decode through a one-entry buffer with a valid/ready handshake.
- Sits between the branch unit (execute stage) and decode.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- doBranch  in  1  redirect request from branch unit; covers taken branch, JAL and JALR.
- brTarget  in  XLEN  redirect target (pc+imm or rs1+imm); bit0 is cleared here.
- imemReq  out  1  fetch request valid.
- imemAddr  out  XLEN  fetch address, word aligned.
- imemGnt  in  1  request accepted this cycle.
- imemRvalid  in  1  read data valid; at least 1 cycle after the grant.
- imemRdata  in  XLEN  instruction word.
- instValid  out  1  buffer holds a valid instruction.
- instData  out  XLEN  buffered instruction.
- instPC  out  XLEN  address of instData.
- instReady  in  1  decode accepts the buffered instruction.
- misaligned  out  1  sticky instruction-address-misaligned fault.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=REQ, imemReq=0 during the reset cycle, imemAddr=RESET_PC.
  - instValid=0, instData=0, instPC=0, misaligned=0.
  - Reset mid-operation abandons the outstanding request. Any rvalid arriving later is ignored, because state after reset is REQ and rvalid is only accepted in WAIT or DROP.
- States: REQ, WAIT, DROP, HALT.
- REQ:
  - imemReq=1 only when the buffer is empty or being drained this cycle (instValid & instReady). Otherwise imemReq=0.
  - imemAddr=pc.
  - On imemReq & imemGnt: latch reqPC=pc, pc<=pc+4 (wraps modulo 2^XLEN), go to WAIT.
- WAIT:
  - imemReq=0.
  - On imemRvalid: buffer<= {imemRdata, reqPC}, instValid<=1, go to REQ.
- DROP:
  - Entered when a redirect occurs while a granted request is in flight.
  - The next imemRvalid is discarded, then go to REQ. No buffer write.
- HALT:
  - imemReq=0 forever; only rst exits.
- Redirect (doBranch=1, any state except HALT):
  - t = {brTarget[XLEN-1:1],1'b0}.
  - If t[1]=1: misaligned<=1, instValid<=0, go to HALT.
  - Else pc<=t and instValid<=0 next cycle. The buffer is flushed regardless of instReady.
  - Next state by current state and handshake:
    - REQ without grant: REQ, and imemAddr shows t next cycle. Changing an ungranted address is legal on this interface.
    - REQ with grant in the same cycle: DROP.
    - WAIT without rvalid: DROP.
    - WAIT with rvalid: the data is discarded, go to REQ.
    - DROP: stay in DROP if no rvalid, else go to REQ.
- Latency:
  - Redirect at edge N → imemReq with addr t during cycle N+1.
  - With grant in N+1 and rvalid in N+2 → instValid=1 in N+3.
  - Sequential throughput: one instruction per 2 cycles at zero-wait memory, because only one request is outstanding.
- Decode handshake:
  - instData and instPC hold stable while instValid & !instReady.
  - A transfer occurs on instValid & instReady. The buffer clears unless it is refilled in the same cycle.
- imemAddr is stable while imemReq=1 and no grant, except on redirect.
- doBranch in HALT is ignored.

Decomposition:
- Shared package cpu_pkg:
  - fetch state enum (REQ, WAIT, DROP, HALT).
  - XLEN and RESET_PC defaults.
  - ILEN=4 PC increment constant.
- One natural sub-module: fetch_buf, a one-entry valid/ready holding register with a synchronous flush input.
  - Instantiated once for {instData, instPC}.

Test Plan:
- Reset release, zero-wait memory (gnt same cycle as req, rvalid next cycle), instReady=1 → imemAddr sequence 0x0,0x4,0x8; instPC 0x0,0x4,0x8 with matching instData; instValid every 2nd cycle.
- Back-pressure: instReady=0 for 5 cycles after the first fetch → instData/instPC held at 0x0; imemReq=0 while the buffer is full; resumes with addr 0x4 after the handshake.
- Redirect in WAIT: doBranch=1, brTarget=0x100 while the request for 0x8 is in flight → the rvalid for 0x8 is discarded; the next imemAddr is 0x100; the first delivered instPC is 0x100.
- Redirect coincident with grant in REQ, plus a JALR-style brTarget=0x201 → bit0 cleared, DROP taken, next fetch addr 0x200, no stale instruction delivered.
- Misaligned target brTarget=0x102 → misaligned=1 next cycle and stays 1; instValid=0; imemReq stays 0; rst clears it and fetch restarts at RESET_PC.
- Reset mid-fetch: rst asserted in WAIT, rvalid arriving during the rst cycle → no instValid; first post-reset imemAddr=RESET_PC.
